cpu8_top: RTL and testbench

// - Top level of an 8-bit accumulator-style CPU: program RAM, PC, 4x8 register file, decoder FSM, ALU.
// - Executes from internal 256x8 program RAM after reset; result register A mirrored on leds.
// - Board-facing LCD and SPI-flash pins are provided; flash boot is optional, LCD pins are reserved.

---
 rtl/cpu8_pkg.sv | 67 ++++++
 rtl/cpu8_alu.sv | 33 +++
 rtl/cpu8_top.sv | 224 ++++++++++++++++++++++
 tb/tb_cpu8_top.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu8_pkg.sv
// Shared definitions for the cpu8 accumulator CPU: decoder states, opcode classes,
// register indices, ALU operation codes and instruction-class helpers.
package cpu8_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_FETCH_OP  = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    REG_A = 2'd0,
    REG_B = 2'd1,
    REG_C = 2'd2,
    REG_D = 2'd3
  } reg_idx_e;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_INC  = 3'd1,
    ALU_DEC  = 3'd2,
    ALU_ADD  = 3'd3,
    ALU_SUB  = 3'd4,
    ALU_AND  = 3'd5,
    ALU_OR   = 3'd6
  } alu_op_e;

  localparam logic [3:0] CLS_MOV  = 4'h0;
  localparam logic [3:0] CLS_MOVI = 4'h1;
  localparam logic [3:0] CLS_JMP  = 4'h3;
  localparam logic [3:0] CLS_INC  = 4'h8;
  localparam logic [3:0] CLS_DEC  = 4'h9;
  localparam logic [3:0] CLS_ADD  = 4'hC;
  localparam logic [3:0] CLS_SUB  = 4'hD;
  localparam logic [3:0] CLS_AND  = 4'hE;
  localparam logic [3:0] CLS_OR   = 4'hF;

  function automatic logic is_two_byte(input logic [3:0] cls);
    return (cls == CLS_MOVI) || (cls == CLS_JMP);
  endfunction

  function automatic logic sets_flags(input logic [3:0] cls);
    return (cls == CLS_INC) || (cls == CLS_DEC) || (cls == CLS_ADD) ||
           (cls == CLS_SUB) || (cls == CLS_AND) || (cls == CLS_OR);
  endfunction

  function automatic logic writes_reg(input logic [3:0] cls);
    return (cls == CLS_MOV) || (cls == CLS_MOVI) || sets_flags(cls);
  endfunction

  function automatic alu_op_e alu_op_of(input logic [3:0] cls);
    alu_op_e op;
    case (cls)
      CLS_INC: op = ALU_INC;
      CLS_DEC: op = ALU_DEC;
      CLS_ADD: op = ALU_ADD;
      CLS_SUB: op = ALU_SUB;
      CLS_AND: op = ALU_AND;
      CLS_OR:  op = ALU_OR;
      default: op = ALU_PASS;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cpu8_alu.sv
// Combinational 8-bit ALU: result is mod 256, c is carry/borrow/wrap for arithmetic
// and 0 for pass/logic ops, z flags a zero result.
module cpu8_alu
  import cpu8_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result,
  output logic       z,
  output logic       c
);

  logic [8:0] wide;

  always_comb begin
    wide = 9'd0;
    c    = 1'b0;
    case (alu_op_e'(op))
      ALU_INC: begin wide = {1'b0, a} + 9'd1;         c = wide[8]; end
      ALU_DEC: begin wide = {1'b0, a} - 9'd1;         c = wide[8]; end
      ALU_ADD: begin wide = {1'b0, a} + {1'b0, b};    c = wide[8]; end
      // bit 8 of the 9-bit difference is set exactly when b > a
      ALU_SUB: begin wide = {1'b0, a} - {1'b0, b};    c = wide[8]; end
      ALU_AND: wide = {1'b0, a & b};
      ALU_OR:  wide = {1'b0, a | b};
      default: wide = {1'b0, b};
    endcase
    result = wide[7:0];
    z      = (result == 8'd0);
  end

endmodule

// File: rtl/cpu8_top.sv
// cpu8 top: program RAM, PC, 4x8 register file, multi-cycle decoder FSM and ALU.
// Define FLASH_BOOT_EN to add the btn2-triggered SPI flash loader that fills program RAM.
module cpu8_top
  import cpu8_pkg::*;
#(
  parameter int PRAM_DEPTH = 256
) (
  input  logic       sys_clk,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       flash_MISO,
  output logic [7:0] lcd_ctrl,
  output logic       lcd_en,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic       flash_MOSI,
  output logic       flash_clk,
  output logic       flash_cs,
  output logic [7:0] leds
);

  logic [7:0] mem [0:PRAM_DEPTH-1];
  logic [7:0] cpu_regs [0:3];

  state_e     state_q, state_d, state;
  logic [7:0] pc_q, pc_d, pc;
  logic [7:0] ir_q, ir_d, opnd_q, opnd_d, res_q, res_d;
  logic       z_q, z_d, c_q, c_d;
  logic       rf_we;

  logic       halt, boot_done;
  logic       ld_we;
  logic [7:0] ld_addr, ld_data;

  logic [3:0] cls;
  logic [1:0] rd, rs;
  logic [7:0] alu_b, alu_res;
  logic       alu_z, alu_c;

  assign pc    = pc_q;
  assign state = state_q;
  assign cls   = ir_q[7:4];
  assign rd    = ir_q[3:2];
  assign rs    = ir_q[1:0];
  assign alu_b = (cls == CLS_MOVI) ? opnd_q : cpu_regs[rs];

  cpu8_alu u_alu (
    .op     (alu_op_of(cls)),
    .a      (cpu_regs[rd]),
    .b      (alu_b),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    z_d     = z_q;
    c_d     = c_q;
    rf_we   = 1'b0;
    if (!halt) begin
      case (state)
        S_FETCH: begin
          ir_d    = mem[pc];
          pc_d    = pc_q + 8'd1;
          state_d = S_DECODE;
        end
        S_DECODE: state_d = is_two_byte(cls) ? S_FETCH_OP : S_EXECUTE;
        S_FETCH_OP: begin
          opnd_d  = mem[pc];
          pc_d    = pc_q + 8'd1;
          state_d = S_EXECUTE;
        end
        S_EXECUTE: begin
          res_d = alu_res;
          if (sets_flags(cls)) begin
            z_d = alu_z;
            c_d = alu_c;
          end
          state_d = S_WRITEBACK;
        end
        S_WRITEBACK: begin
          if (cls == CLS_JMP) pc_d = opnd_q;
          rf_we   = writes_reg(cls);
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
    if (boot_done) begin
      pc_d    = 8'd0;
      state_d = S_FETCH;
    end
  end

  // control state and architectural registers
  always_ff @(posedge sys_clk) begin
    if (btn1) begin
      state_q <= S_FETCH;
      pc_q    <= 8'd0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      for (int i = 0; i < 4; i++) cpu_regs[i] <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      z_q     <= z_d;
      c_q     <= c_d;
      if (rf_we) cpu_regs[rd] <= res_q;
    end
  end

  // instruction datapath; state_q returning to FETCH makes stale contents harmless
  always_ff @(posedge sys_clk) begin
    ir_q   <= ir_d;
    opnd_q <= opnd_d;
    res_q  <= res_d;
  end

  always_ff @(posedge sys_clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
  end

`ifdef FLASH_BOOT_EN
  logic [2:0]  b2_sync_q;
  logic        boot_q, boot_d, fclk_q, fclk_d, in_cmd_q, in_cmd_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d, byte_cnt_q, byte_cnt_d;
  logic        boot_start;

  assign boot_start = b2_sync_q[1] & ~b2_sync_q[2] & ~boot_q;

  always_comb begin
    boot_d     = boot_q;
    fclk_d     = fclk_q;
    in_cmd_d   = in_cmd_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    byte_cnt_d = byte_cnt_q;
    ld_we      = 1'b0;
    ld_addr    = byte_cnt_q;
    ld_data    = rx_q;
    boot_done  = 1'b0;
    if (boot_start) begin
      boot_d     = 1'b1;
      fclk_d     = 1'b0;
      in_cmd_d   = 1'b1;
      bit_cnt_d  = 5'd0;
      tx_d       = 32'h0300_0000;
      byte_cnt_d = 8'd0;
    end else if (boot_q) begin
      if (!fclk_q) begin
        fclk_d = 1'b1;
        if (!in_cmd_q) rx_d = {rx_q[6:0], flash_MISO};
      end else begin
        // falling edge: advance MOSI, count the bit; 5-bit counter wraps to 0 after the command
        fclk_d    = 1'b0;
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (in_cmd_q) begin
          tx_d = {tx_q[30:0], 1'b0};
          if (bit_cnt_q == 5'd31) in_cmd_d = 1'b0;
        end else if (bit_cnt_q[2:0] == 3'd7) begin
          ld_we      = 1'b1;
          byte_cnt_d = byte_cnt_q + 8'd1;
          if (byte_cnt_q == 8'(PRAM_DEPTH - 1)) begin
            boot_d    = 1'b0;
            boot_done = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (btn1) begin
      b2_sync_q <= 3'd0;
      boot_q    <= 1'b0;
      fclk_q    <= 1'b0;
      in_cmd_q  <= 1'b0;
    end else begin
      b2_sync_q <= {b2_sync_q[1:0], btn2};
      boot_q    <= boot_d;
      fclk_q    <= fclk_d;
      in_cmd_q  <= in_cmd_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    bit_cnt_q  <= bit_cnt_d;
    tx_q       <= tx_d;
    rx_q       <= rx_d;
    byte_cnt_q <= byte_cnt_d;
  end

  assign halt       = boot_q;
  assign flash_cs   = ~boot_q;
  assign flash_clk  = fclk_q;
  assign flash_MOSI = boot_q & in_cmd_q & tx_q[31];
`else
  logic unused_flash_in;
  assign unused_flash_in = btn2 ^ flash_MISO;
  assign halt       = 1'b0;
  assign boot_done  = 1'b0;
  assign ld_we      = 1'b0;
  assign ld_addr    = 8'd0;
  assign ld_data    = 8'd0;
  assign flash_cs   = 1'b1;
  assign flash_clk  = 1'b0;
  assign flash_MOSI = 1'b0;
`endif

  assign leds     = cpu_regs[REG_A];
  assign lcd_ctrl = 8'd0;
  assign lcd_en   = 1'b0;
  assign lcd_rw   = 1'b0;
  assign lcd_rs   = 1'b0;

endmodule

// File: tb/tb_cpu8_top.sv
// Directed bench for cpu8_top: small hand-assembled programs loaded into program RAM,
// register/flag/PC values checked against hand-computed results.
module tb_cpu8_top;

  logic       sys_clk = 1'b0;
  logic       btn1 = 1'b1;
  logic       btn2 = 1'b0;
  logic       flash_MISO = 1'b0;
  logic [7:0] lcd_ctrl, leds;
  logic       lcd_en, lcd_rw, lcd_rs, flash_MOSI, flash_clk, flash_cs;

  int checks = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  cpu8_top dut (
    .sys_clk    (sys_clk),
    .btn1       (btn1),
    .btn2       (btn2),
    .flash_MISO (flash_MISO),
    .lcd_ctrl   (lcd_ctrl),
    .lcd_en     (lcd_en),
    .lcd_rw     (lcd_rw),
    .lcd_rs     (lcd_rs),
    .flash_MOSI (flash_MOSI),
    .flash_clk  (flash_clk),
    .flash_cs   (flash_cs),
    .leds       (leds)
  );

`ifdef FLASH_BOOT_EN
  // flash model: byte i at address i, MSB first, data changes on falling flash_clk
  int          rise_cnt = 0;
  int          dbit;
  logic [31:0] cmd_word = 32'd0;
  logic [7:0]  fbyte;
  always @(posedge flash_clk) begin
    if (!flash_cs) begin
      if (rise_cnt < 32) cmd_word = {cmd_word[30:0], flash_MOSI};
      rise_cnt = rise_cnt + 1;
    end
  end
  always @(negedge flash_clk) begin
    if (!flash_cs && rise_cnt >= 32) begin
      dbit       = rise_cnt - 32;
      fbyte      = 8'((dbit / 8) % 256);
      flash_MISO = fbyte[7 - (dbit % 8)];
    end
  end
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic clear_pram();
    for (int i = 0; i < 256; i++) dut.mem[i] = 8'h00;
  endtask

  // wait until the CPU sits in state st with pc == pc_t
  task automatic wait_at(input logic [7:0] pc_t, input logic [2:0] st, input int budget,
                         input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge sys_clk);
      if (dut.pc === pc_t && dut.state === st) found = 1'b1;
    end
    check(tag, {31'd0, found}, 32'd1);
  endtask

  initial begin
    // program 1: MOV A,42; MOV B,10; ADD A,B; MOV C,A
    clear_pram();
    dut.mem[0] = 8'h10; dut.mem[1] = 8'h42; dut.mem[2] = 8'h14; dut.mem[3] = 8'h10;
    dut.mem[4] = 8'hC1; dut.mem[5] = 8'h08;
    cycles(3);
    check("rst_pc", dut.pc, 8'h00);
    check("rst_state", dut.state, 3'd0);
    check("rst_leds", leds, 8'h00);
    check("rst_flash_cs", flash_cs, 1'b1);
    check("rst_flash_clk", flash_clk, 1'b0);
    check("rst_flash_mosi", flash_MOSI, 1'b0);
    check("rst_lcd", {lcd_ctrl, lcd_en, lcd_rw, lcd_rs}, 11'd0);

    btn1 = 1'b0;
    cycles(80);
    check("p1_A", dut.cpu_regs[0], 8'h52);
    check("p1_B", dut.cpu_regs[1], 8'h10);
    check("p1_C", dut.cpu_regs[2], 8'h52);
    check("p1_D", dut.cpu_regs[3], 8'h00);
    check("p1_leds", leds, 8'h52);

    btn1 = 1'b1;
    cycles(3);
    check("rst2_pc", dut.pc, 8'h00);
    check("rst2_state", dut.state, 3'd0);
    check("rst2_regs", {dut.cpu_regs[0], dut.cpu_regs[1], dut.cpu_regs[2], dut.cpu_regs[3]}, 32'd0);
    check("rst2_flags", {dut.z_q, dut.c_q}, 2'b00);
    check("rst2_leds", leds, 8'h00);
    check("rst2_pram0", dut.mem[0], 8'h10);
    check("rst2_pram4", dut.mem[4], 8'hC1);

    // program 2: MOV A,FF; MOV B,01; ADD A,B; SUB A,B
    clear_pram();
    dut.mem[0] = 8'h10; dut.mem[1] = 8'hFF; dut.mem[2] = 8'h14; dut.mem[3] = 8'h01;
    dut.mem[4] = 8'hC1; dut.mem[5] = 8'hD1;
    btn1 = 1'b0;
    wait_at(8'h05, 3'd0, 60, "p2_reach_add_done");
    check("p2_add_A", dut.cpu_regs[0], 8'h00);
    check("p2_add_Z", dut.z_q, 1'b1);
    check("p2_add_C", dut.c_q, 1'b1);
    wait_at(8'h06, 3'd0, 20, "p2_reach_sub_done");
    check("p2_sub_A", dut.cpu_regs[0], 8'hFF);
    check("p2_sub_C", dut.c_q, 1'b1);
    check("p2_sub_Z", dut.z_q, 1'b0);

    // program 3: JMP 10; at 10: MOV A,AA; JMP FE; at FE: MOV A,55 (operand at FF, PC wraps)
    btn1 = 1'b1;
    cycles(2);
    clear_pram();
    dut.mem[8'h00] = 8'h30; dut.mem[8'h01] = 8'h10;
    dut.mem[8'h10] = 8'h10; dut.mem[8'h11] = 8'hAA;
    dut.mem[8'h12] = 8'h30; dut.mem[8'h13] = 8'hFE;
    dut.mem[8'hFE] = 8'h10; dut.mem[8'hFF] = 8'h55;
    btn1 = 1'b0;
    wait_at(8'h10, 3'd0, 20, "p3_jmp_10");
    check("p3_A_before", dut.cpu_regs[0], 8'h00);
    wait_at(8'h12, 3'd0, 20, "p3_movi_aa");
    check("p3_A_aa", dut.cpu_regs[0], 8'hAA);
    wait_at(8'hFE, 3'd0, 20, "p3_jmp_fe");
    wait_at(8'h00, 3'd0, 20, "p3_wrap_00");
    check("p3_A_55", dut.cpu_regs[0], 8'h55);
    check("p3_flags_kept", {dut.z_q, dut.c_q}, 2'b00);

    // reset during EXECUTE of ADD A,B
    btn1 = 1'b1;
    cycles(2);
    clear_pram();
    dut.mem[0] = 8'h10; dut.mem[1] = 8'h42; dut.mem[2] = 8'h14; dut.mem[3] = 8'h10;
    dut.mem[4] = 8'hC1; dut.mem[5] = 8'h08;
    btn1 = 1'b0;
    wait_at(8'h04, 3'd0, 30, "p4_reach_add");
    check("p4_A_pre", dut.cpu_regs[0], 8'h42);
    wait_at(8'h05, 3'd3, 5, "p4_reach_execute");
    btn1 = 1'b1;
    @(negedge sys_clk);
    check("p4_A_no_write", dut.cpu_regs[0], 8'h00);
    check("p4_B_cleared", dut.cpu_regs[1], 8'h00);
    check("p4_pc_restart", dut.pc, 8'h00);
    check("p4_state_restart", dut.state, 3'd0);
    btn1 = 1'b0;
    wait_at(8'h04, 3'd0, 30, "p4_rerun_movs");
    check("p4_rerun_A", dut.cpu_regs[0], 8'h42);
    wait_at(8'h05, 3'd0, 10, "p4_rerun_add");
    check("p4_rerun_add_A", dut.cpu_regs[0], 8'h52);

`ifdef FLASH_BOOT_EN
    begin
      logic seen;
      btn1 = 1'b1;
      cycles(2);
      clear_pram();
      btn1 = 1'b0;
      cycles(2);
      btn2 = 1'b1;
      cycles(4);
      btn2 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge sys_clk);
        if (flash_cs === 1'b0) seen = 1'b1;
      end
      check("fb_cs_low", {31'd0, seen}, 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 6000 && !seen; i++) begin
        @(negedge sys_clk);
        if (flash_cs === 1'b1) seen = 1'b1;
      end
      check("fb_cs_high", {31'd0, seen}, 32'd1);
      check("fb_cmd", cmd_word, 32'h0300_0000);
      check("fb_pc", dut.pc, 8'h00);
      check("fb_state", dut.state, 3'd0);
      check("fb_pram5", dut.mem[5], 8'h05);
      check("fb_pramff", dut.mem[255], 8'hFF);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
